aer_arbiter: RTL and testbench
==============================

AER_ARBITER -- requirements
Module: aer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sorter lanes sharing the AER transmitter.
REQ-002 Parameter ADDR_BITS, default 10: pixel-index width (IMAGE_SIZE_BITS+2 for IMAGE_SIZE=256).
REQ-003 Parameter TIMEOUT, default 7: WAIT_BUSY cycles before a reissue.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RSTN  in  1  asynchronous, active-low reset.
REQ-006 ENABLE  in  1  permits new grants.
REQ-007 REQ_VALID  in  NUM_REQ  per-lane index valid.
REQ-008 REQ_INDEX  in  NUM_REQ*ADDR_BITS  packed lane indices; lane i occupies bits [i*ADDR_BITS +: ADDR_BITS].
REQ-009 REQ_READY  out  NUM_REQ  one-hot accept pulse.
REQ-010 NEXT_INDEX  out  ADDR_BITS  index presented to the AER transmitter.
REQ-011 FOUND_NEXT_INDEX  out  1  one-cycle issue strobe to the transmitter.
REQ-012 AERIN_CTRL_BUSY  in  1  transmitter busy flag.
REQ-013 GRANT_ID  out  $clog2(NUM_REQ)  lane owning the current/last transaction.
REQ-014 ARB_IDLE  out  1  high only in IDLE.
REQ-015 EVENT_COUNT  out  16  completed transactions, saturating.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; all outputs SHALL be registered or decoded from state registers only.
REQ-017 IDLE -> ISSUE SHALL occur when ENABLE=1, |REQ_VALID=1 and AERIN_CTRL_BUSY=0; otherwise the FSM SHALL stay in IDLE.
REQ-018 On the IDLE->ISSUE edge, the winning lane's index SHALL load into NEXT_INDEX and its number into GRANT_ID.
REQ-019 Arbitration SHALL be round-robin: search starts at lane (last_grant+1) mod NUM_REQ; last_grant updates on every new grant.
REQ-020 In ISSUE, FOUND_NEXT_INDEX SHALL be 1 for exactly one cycle, then ISSUE -> WAIT_BUSY.
REQ-021 REQ_READY[GRANT_ID] SHALL pulse high for one cycle, coincident with the first ISSUE of a transaction only; all other REQ_READY bits SHALL stay 0.
REQ-022 Requesters SHALL hold REQ_VALID and REQ_INDEX stable until REQ_READY; the arbiter SHALL not sample REQ_INDEX after the grant edge.
REQ-023 In WAIT_BUSY, AERIN_CTRL_BUSY=1 SHALL move to WAIT_DONE and clear the 3-bit timeout counter.
REQ-024 In WAIT_BUSY, after TIMEOUT consecutive cycles with AERIN_CTRL_BUSY=0, the FSM SHALL return to ISSUE and reissue FOUND_NEXT_INDEX with unchanged NEXT_INDEX, without a REQ_READY pulse.
REQ-025 In WAIT_DONE, AERIN_CTRL_BUSY=0 SHALL move to IDLE and increment EVENT_COUNT; at 16'hFFFF the count SHALL hold.
REQ-026 ENABLE deassertion SHALL block only new grants; an in-flight transaction SHALL complete through WAIT_DONE.
REQ-027 Minimum spacing between FOUND_NEXT_INDEX pulses of distinct transactions SHALL be 4 cycles.
REQ-028 A REQ_VALID deasserted before grant SHALL be ignored with no REQ_READY issued.

Reset
REQ-029 RSTN=0 SHALL immediately force IDLE, and clear REQ_READY, FOUND_NEXT_INDEX, NEXT_INDEX, GRANT_ID, EVENT_COUNT and the timeout counter to 0; ARB_IDLE SHALL then be 1.
REQ-030 Reset SHALL set last_grant to NUM_REQ-1, so lane 0 has first priority.
REQ-031 Reset mid-transaction SHALL abandon it with no REQ_READY or count update; the first post-reset grant SHALL follow REQ-017.

Verification
REQ-032 Single request: lane 2 valid, index 10'h155; BUSY rises 1 cycle after strobe and falls 5 cycles later -> one FOUND pulse, NEXT_INDEX=10'h155, REQ_READY=4'b0100, GRANT_ID=2, EVENT_COUNT=1.
REQ-033 All four lanes continuously valid, 8 transactions -> GRANT_ID sequence 0,1,2,3,0,1,2,3.
REQ-034 BUSY held 0 after strobe -> FOUND reissued after 7 cycles with the same NEXT_INDEX, only one REQ_READY pulse, and no count increment until BUSY rises then falls.
REQ-035 ENABLE dropped during WAIT_DONE with lanes valid -> transaction completes, EVENT_COUNT increments, FSM remains IDLE until ENABLE=1.
REQ-036 RSTN pulsed low in WAIT_BUSY -> all outputs 0 and ARB_IDLE=1 immediately; next grant goes to lane 0.
REQ-037 EVENT_COUNT preloaded to 16'hFFFE by forcing the internal counter, then 3 transactions -> counts 16'hFFFF, 16'hFFFF, 16'hFFFF.

Source files
------------

// File: rtl/aer_arbiter.sv
// Round-robin arbiter that lets several sorter lanes share one AER transmitter.
// It grants one lane, strobes its index, and reissues the strobe if the transmitter never goes busy.
module aer_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int ADDR_BITS = 10,
   parameter  int TIMEOUT   = 7,
   localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rstn,
   input  logic                         i_enable,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*ADDR_BITS-1:0] i_req_index,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [ADDR_BITS-1:0]         o_next_index,
   output logic                         o_found_next_index,
   input  logic                         i_aerin_ctrl_busy,
   output logic [GW-1:0]                o_grant_id,
   output logic                         o_arb_idle,
   output logic [15:0]                  o_event_count
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [2:0]           r_to_cnt, w_to_cnt_nxt;
   logic                 r_first;
   logic [GW-1:0]        r_last_grant;
   logic [GW-1:0]        r_grant_id;
   logic [ADDR_BITS-1:0] r_next_index;
   logic [15:0]          r_event_count;

   logic                 w_hi_found, w_lo_found;
   logic [GW-1:0]        w_hi_id, w_lo_id, w_win_id;
   logic [ADDR_BITS-1:0] w_win_index;
   logic                 w_grant;

   // Lanes above last_grant win over lanes at or below it; lowest index wins within each group.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_id    = '0;
      w_lo_id    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_valid[i]) begin
            if (GW'(i) > r_last_grant) begin
               w_hi_found = 1'b1;
               w_hi_id    = GW'(i);
            end else begin
               w_lo_found = 1'b1;
               w_lo_id    = GW'(i);
            end
         end
      end
      w_win_id = w_hi_found ? w_hi_id : w_lo_id;
   end

   always_comb begin
      w_win_index = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (GW'(i) == w_win_id) w_win_index = i_req_index[i*ADDR_BITS +: ADDR_BITS];
      end
   end

   assign w_grant = (r_state == S_IDLE) && i_enable && (|i_req_valid) && !i_aerin_ctrl_busy;

   always_comb begin
      w_state_nxt  = r_state;
      w_to_cnt_nxt = r_to_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_state_nxt  = S_WAIT_BUSY;
            w_to_cnt_nxt = '0;
         end
         S_WAIT_BUSY: begin
            if (i_aerin_ctrl_busy) begin
               w_state_nxt  = S_WAIT_DONE;
               w_to_cnt_nxt = '0;
            end else if (r_to_cnt == 3'(TIMEOUT - 1)) begin
               w_state_nxt  = S_ISSUE;
               w_to_cnt_nxt = '0;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 3'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!i_aerin_ctrl_busy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state       <= S_IDLE;
         r_to_cnt      <= '0;
         r_first       <= 1'b0;
         r_last_grant  <= GW'(NUM_REQ - 1);
         r_grant_id    <= '0;
         r_next_index  <= '0;
         r_event_count <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_to_cnt <= w_to_cnt_nxt;
         if (w_grant) begin
            r_next_index <= w_win_index;
            r_grant_id   <= w_win_id;
            r_last_grant <= w_win_id;
            r_first      <= 1'b1;
         end else if (r_state == S_ISSUE) begin
            // Timeout reissues must not acknowledge the requester a second time.
            r_first <= 1'b0;
         end
         if ((r_state == S_WAIT_DONE) && !i_aerin_ctrl_busy && (r_event_count != 16'hFFFF))
            r_event_count <= r_event_count + 16'd1;
      end
   end

   assign o_found_next_index = (r_state == S_ISSUE);
   assign o_req_ready        = ((r_state == S_ISSUE) && r_first) ? (NUM_REQ'(1) << r_grant_id) : '0;
   assign o_next_index       = r_next_index;
   assign o_grant_id         = r_grant_id;
   assign o_arb_idle         = (r_state == S_IDLE);
   assign o_event_count      = r_event_count;

endmodule

// File: tb/tb_aer_arbiter.sv
// Bench for aer_arbiter: directed scenarios plus randomized lane masks,
// checked against a round-robin/counting reference model.
module tb_aer_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int ADDR_BITS = 10;
   localparam int TIMEOUT   = 7;

   logic        clk = 1'b0;
   logic        rstn, enable, busy;
   logic [3:0]  valid;
   logic [39:0] index;
   logic [3:0]  ready;
   logic [9:0]  next_index;
   logic        found;
   logic [1:0]  gid;
   logic        arb_idle;
   logic [15:0] count;

   int n_chk = 0, n_pass = 0;
   int mon_found = 0, mon_ready = 0;
   int m_last, m_count;
   logic [9:0] lane_idx [4];

   aer_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_req_valid(valid), .i_req_index(index),
      .o_req_ready(ready), .o_next_index(next_index), .o_found_next_index(found),
      .i_aerin_ctrl_busy(busy), .o_grant_id(gid), .o_arb_idle(arb_idle), .o_event_count(count));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (found === 1'b1) mon_found++;
      if (ready !== 4'b0000) mon_ready++;
   end

   // Reference: next grant is the first valid lane after last_grant, wrapping around.
   function automatic int rr_pick(input logic [3:0] mask, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (last + k) % NUM_REQ;
         if (mask[j]) return j;
      end
      return -1;
   endfunction

   function automatic int sat_inc(input int c);
      return (c >= 65535) ? 65535 : c + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_found(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (found === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Called while in ISSUE; transmitter goes busy after dly cycles, stays busy len cycles.
   task automatic run_busy(input int dly, input int len);
      step();
      repeat (dly) step();
      busy = 1'b1;
      repeat (len) step();
      busy = 1'b0;
      step();
   endtask

   task automatic apply_reset();
      rstn = 1'b0; valid = '0; busy = 1'b0; enable = 1'b1;
      step();
      rstn = 1'b1;
      m_last = NUM_REQ - 1;
      m_count = 0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; valid = '0; busy = 1'b0; enable = 1'b1; index = '0;
      step(); step();
      n_chk++; if (arb_idle !== 1'b1) $display("FAIL rst_idle: got %b need 1", arb_idle); else n_pass++;
      n_chk++; if (found !== 1'b0) $display("FAIL rst_found: got %b need 0", found); else n_pass++;
      n_chk++; if (ready !== 4'b0) $display("FAIL rst_ready: got %b need 0000", ready); else n_pass++;
      n_chk++; if (next_index !== 10'h0) $display("FAIL rst_index: got %h need 000", next_index); else n_pass++;
      n_chk++; if (gid !== 2'd0) $display("FAIL rst_gid: got %0d need 0", gid); else n_pass++;
      n_chk++; if (count !== 16'h0) $display("FAIL rst_count: got %h need 0000", count); else n_pass++;
      rstn = 1'b1;
      m_last = NUM_REQ - 1;
      m_count = 0;
   endtask

   task automatic test_single();
      bit ok;
      int bf, br;
      bf = mon_found; br = mon_ready;
      index = {$urandom, $urandom};
      index[20 +: 10] = 10'h155;
      valid = 4'b0100;
      wait_found(ok);
      n_chk++; if (!ok) $display("FAIL single_found: got none need strobe"); else n_pass++;
      n_chk++; if (gid !== 2'd2) $display("FAIL single_gid: got %0d need 2", gid); else n_pass++;
      n_chk++; if (next_index !== 10'h155) $display("FAIL single_index: got %h need 155", next_index); else n_pass++;
      n_chk++; if (ready !== 4'b0100) $display("FAIL single_ready: got %b need 0100", ready); else n_pass++;
      valid = '0;
      m_last = 2;
      run_busy(0, 5);
      m_count = sat_inc(m_count);
      n_chk++; if (count !== 16'(m_count)) $display("FAIL single_count: got %0d need %0d", count, m_count); else n_pass++;
      n_chk++; if (arb_idle !== 1'b1) $display("FAIL single_idle: got %b need 1", arb_idle); else n_pass++;
      n_chk++; if (mon_found - bf != 1) $display("FAIL single_npulse: got %0d need 1", mon_found - bf); else n_pass++;
      n_chk++; if (mon_ready - br != 1) $display("FAIL single_nready: got %0d need 1", mon_ready - br); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         lane_idx[i] = 10'($urandom);
         index[i*10 +: 10] = lane_idx[i];
      end
      valid = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         wait_found(ok);
         n_chk++; if (!ok) $display("FAIL rr_found%0d: got none need strobe", t); else n_pass++;
         n_chk++; if (gid !== 2'(exp_seq[t])) $display("FAIL rr_gid%0d: got %0d need %0d", t, gid, exp_seq[t]); else n_pass++;
         n_chk++; if (next_index !== lane_idx[exp_seq[t]]) $display("FAIL rr_index%0d: got %h need %h", t, next_index, lane_idx[exp_seq[t]]); else n_pass++;
         n_chk++; if (ready !== 4'(1 << exp_seq[t])) $display("FAIL rr_ready%0d: got %b need %b", t, ready, 4'(1 << exp_seq[t])); else n_pass++;
         m_last = exp_seq[t];
         run_busy(0, 1);
         m_count = sat_inc(m_count);
      end
      valid = '0;
      n_chk++; if (count !== 16'(m_count)) $display("FAIL rr_count: got %0d need %0d", count, m_count); else n_pass++;
   endtask

   task automatic test_timeout();
      bit ok, seen;
      int br, cyc, lane, exp;
      logic [9:0] idx;
      br = mon_ready;
      lane = $urandom_range(0, 3);
      idx = 10'($urandom);
      index[lane*10 +: 10] = idx;
      valid = 4'(1 << lane);
      exp = rr_pick(valid, m_last);
      wait_found(ok);
      n_chk++; if (!ok || gid !== 2'(exp)) $display("FAIL to_gid: got %0d need %0d", gid, exp); else n_pass++;
      m_last = exp;
      valid = '0;
      index[lane*10 +: 10] = ~idx;
      seen = 1'b0; cyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (!seen) begin
            step();
            cyc++;
            if (found === 1'b1) seen = 1'b1;
         end
      end
      n_chk++; if (!seen || cyc != TIMEOUT + 1) $display("FAIL to_reissue: got %0d cycles need %0d", cyc, TIMEOUT + 1); else n_pass++;
      n_chk++; if (next_index !== idx) $display("FAIL to_index: got %h need %h", next_index, idx); else n_pass++;
      n_chk++; if (ready !== 4'b0) $display("FAIL to_ready: got %b need 0000", ready); else n_pass++;
      n_chk++; if (count !== 16'(m_count)) $display("FAIL to_nocount: got %0d need %0d", count, m_count); else n_pass++;
      run_busy(2, 2);
      m_count = sat_inc(m_count);
      n_chk++; if (count !== 16'(m_count)) $display("FAIL to_count: got %0d need %0d", count, m_count); else n_pass++;
      n_chk++; if (mon_ready - br != 1) $display("FAIL to_nready: got %0d need 1", mon_ready - br); else n_pass++;
   endtask

   task automatic test_enable_drop();
      bit ok;
      int bf, exp;
      valid = 4'b1111;
      exp = rr_pick(valid, m_last);
      wait_found(ok);
      n_chk++; if (!ok || gid !== 2'(exp)) $display("FAIL en_gid: got %0d need %0d", gid, exp); else n_pass++;
      m_last = exp;
      step();
      busy = 1'b1;
      step();
      enable = 1'b0;
      busy = 1'b0;
      step();
      m_count = sat_inc(m_count);
      n_chk++; if (count !== 16'(m_count)) $display("FAIL en_count: got %0d need %0d", count, m_count); else n_pass++;
      bf = mon_found;
      repeat (5) step();
      n_chk++; if (arb_idle !== 1'b1) $display("FAIL en_idle: got %b need 1", arb_idle); else n_pass++;
      n_chk++; if (mon_found != bf) $display("FAIL en_blocked: got %0d strobes need 0", mon_found - bf); else n_pass++;
      enable = 1'b1;
      exp = rr_pick(valid, m_last);
      wait_found(ok);
      n_chk++; if (!ok || gid !== 2'(exp)) $display("FAIL en_regrant: got %0d need %0d", gid, exp); else n_pass++;
      m_last = exp;
      valid = '0;
      run_busy(0, 1);
      m_count = sat_inc(m_count);
   endtask

   task automatic test_reset_mid();
      bit ok;
      valid = 4'b1111;
      wait_found(ok);
      step();
      n_chk++; if (arb_idle !== 1'b0) $display("FAIL rm_busywait: got idle %b need 0", arb_idle); else n_pass++;
      rstn = 1'b0;
      #1;
      n_chk++; if (arb_idle !== 1'b1 || found !== 1'b0 || ready !== 4'b0)
         $display("FAIL rm_ctrl: got idle=%b found=%b ready=%b need 1 0 0000", arb_idle, found, ready); else n_pass++;
      n_chk++; if (next_index !== 10'h0 || gid !== 2'd0 || count !== 16'h0)
         $display("FAIL rm_data: got idx=%h gid=%0d cnt=%0d need 0 0 0", next_index, gid, count); else n_pass++;
      step();
      rstn = 1'b1;
      m_last = NUM_REQ - 1;
      m_count = 0;
      wait_found(ok);
      n_chk++; if (!ok || gid !== 2'd0) $display("FAIL rm_lane0: got %0d need 0", gid); else n_pass++;
      m_last = 0;
      valid = '0;
      run_busy(0, 1);
      m_count = sat_inc(m_count);
      n_chk++; if (count !== 16'(m_count)) $display("FAIL rm_count: got %0d need %0d", count, m_count); else n_pass++;
   endtask

   task automatic test_saturate();
      bit ok;
      int exp;
      force dut.r_event_count = 16'hFFFE;
      step();
      release dut.r_event_count;
      step();
      m_count = 65534;
      n_chk++; if (count !== 16'hFFFE) $display("FAIL sat_preload: got %h need fffe", count); else n_pass++;
      for (int t = 0; t < 3; t++) begin
         valid = 4'($urandom_range(1, 15));
         exp = rr_pick(valid, m_last);
         wait_found(ok);
         n_chk++; if (!ok || gid !== 2'(exp)) $display("FAIL sat_gid%0d: got %0d need %0d", t, gid, exp); else n_pass++;
         m_last = exp;
         valid = '0;
         run_busy(0, 1);
         m_count = sat_inc(m_count);
         n_chk++; if (count !== 16'(m_count)) $display("FAIL sat_count%0d: got %h need %h", t, count, 16'(m_count)); else n_pass++;
      end
   endtask

   task automatic test_random();
      bit ok;
      int bf, exp;
      logic [3:0] mask;
      apply_reset();
      for (int t = 0; t < 30; t++) begin
         mask = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            lane_idx[i] = 10'($urandom);
            index[i*10 +: 10] = lane_idx[i];
         end
         valid = mask;
         if (mask == 4'b0) begin
            bf = mon_found;
            repeat (3) step();
            n_chk++; if (arb_idle !== 1'b1 || mon_found != bf) $display("FAIL rnd_none%0d: got idle=%b strobes=%0d need 1 0", t, arb_idle, mon_found - bf); else n_pass++;
         end else begin
            exp = rr_pick(mask, m_last);
            wait_found(ok);
            n_chk++; if (!ok || gid !== 2'(exp)) $display("FAIL rnd_gid%0d: got %0d need %0d", t, gid, exp); else n_pass++;
            n_chk++; if (ready !== 4'(1 << exp)) $display("FAIL rnd_ready%0d: got %b need %b", t, ready, 4'(1 << exp)); else n_pass++;
            m_last = exp;
            valid[exp] = 1'b0;
            index[exp*10 +: 10] = ~lane_idx[exp];
            run_busy($urandom_range(0, 3), $urandom_range(1, 4));
            m_count = sat_inc(m_count);
            n_chk++; if (next_index !== lane_idx[exp]) $display("FAIL rnd_index%0d: got %h need %h", t, next_index, lane_idx[exp]); else n_pass++;
            n_chk++; if (count !== 16'(m_count)) $display("FAIL rnd_count%0d: got %0d need %0d", t, count, m_count); else n_pass++;
         end
      end
      valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_enable_drop();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
